// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment capture path: active-low segment patterns
// {a..g}, special decode codes and the run-counter width helper.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;

  // Counter must be able to hold the value STABLE_CYCLES itself.
  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of one active-low segment pattern to a BCD code;
// blank maps to 4'hF, any unknown pattern to 4'hE with err set.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       err
);

  always_comb begin
    code = CODE_ERR;
    err  = 1'b1;
    case (seg)
      SEG_0:     begin code = 4'd0;       err = 1'b0; end
      SEG_1:     begin code = 4'd1;       err = 1'b0; end
      SEG_2:     begin code = 4'd2;       err = 1'b0; end
      SEG_3:     begin code = 4'd3;       err = 1'b0; end
      SEG_4:     begin code = 4'd4;       err = 1'b0; end
      SEG_5:     begin code = 4'd5;       err = 1'b0; end
      SEG_6:     begin code = 4'd6;       err = 1'b0; end
      SEG_7:     begin code = 4'd7;       err = 1'b0; end
      SEG_8:     begin code = 4'd8;       err = 1'b0; end
      SEG_9:     begin code = 4'd9;       err = 1'b0; end
      SEG_BLANK: begin code = CODE_BLANK; err = 1'b0; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Samples a multiplexed 7-segment bus, accepts each digit after a stable run,
// and publishes a full frame of BCD codes over a valid/ready handshake.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_en,
  input  logic [6:0]              seg_in,
  input  logic [N_DIGITS-1:0]     dig_en,
  output logic [4*N_DIGITS-1:0]   out_bcd,
  output logic [N_DIGITS-1:0]     out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int            CW         = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] STABLE_CNT = CW'(STABLE_CYCLES);

  logic [3:0]              dec_code;
  logic                    dec_err;
  logic [4*N_DIGITS-1:0]   shadow_bcd;
  logic [N_DIGITS-1:0]     shadow_err;
  logic [N_DIGITS-1:0]     seen;
  logic [CW-1:0]           run_cnt;
  logic [N_DIGITS-1:0]     last_dig;
  logic [6:0]              last_pat;
  logic                    committed;

  logic                    one_hot;
  logic                    qualified;
  logic                    same_run;
  logic [CW-1:0]           cnt_next;
  logic                    commit;
  logic [N_DIGITS-1:0]     commit_mask;
  logic                    mask_full;
  logic                    publish;

  seg7_to_bcd u_dec (
    .seg  (seg_in),
    .code (dec_code),
    .err  (dec_err)
  );

  always_comb begin
    one_hot   = (dig_en != '0) && ((dig_en & (dig_en - N_DIGITS'(1))) == '0);
    qualified = sample_en && one_hot;
    same_run  = (dig_en == last_dig) && (seg_in == last_pat);
    if (!same_run)
      cnt_next = CW'(1);
    else if (run_cnt == STABLE_CNT)
      cnt_next = run_cnt;
    else
      cnt_next = run_cnt + CW'(1);
    // A run that already committed stays quiet until it is broken.
    commit      = qualified && (cnt_next == STABLE_CNT) && !(same_run && committed);
    commit_mask = commit ? dig_en : '0;
    mask_full   = &seen;
    publish     = mask_full && (!out_valid || out_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt   <= '0;
      last_dig  <= '0;
      last_pat  <= '0;
      committed <= 1'b0;
    end else if (sample_en) begin
      if (qualified) begin
        last_dig  <= dig_en;
        last_pat  <= seg_in;
        run_cnt   <= cnt_next;
        committed <= commit || (same_run && committed);
      end else begin
        run_cnt   <= '0;
        committed <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_bcd <= {N_DIGITS{CODE_BLANK}};
      shadow_err <= '0;
    end else begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (commit_mask[i]) begin
          shadow_bcd[4*i +: 4] <= dec_code;
          shadow_err[i]        <= dec_err;
        end
      end
    end
  end

  // Publishing takes the pre-commit shadow; a same-cycle commit keeps its seen bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen      <= '0;
      out_bcd   <= {N_DIGITS{CODE_BLANK}};
      out_err   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (publish) begin
        seen      <= commit_mask;
        out_bcd   <= shadow_bcd;
        out_err   <= shadow_err;
        out_valid <= 1'b1;
      end else begin
        seen <= seen | commit_mask;
        if (out_ready)
          out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture: a digit-level model predicts frames into a
// queue, and a separate monitor compares every frame the DUT presents.
module tb_seg7_capture;

  localparam int N = 4;
  localparam int S = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_en;
  logic [6:0]    seg_in;
  logic [N-1:0]  dig_en;
  logic [4*N-1:0] out_bcd;
  logic [N-1:0]  out_err;
  logic          out_valid;
  logic          out_ready;

  always #5 clk = ~clk;

  seg7_capture #(.N_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .seg_in    (seg_in),
    .dig_en    (dig_en),
    .out_bcd   (out_bcd),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4*N-1:0] bcd;
    logic [N-1:0]   err;
  } frame_t;

  frame_t exp_q[$];

  logic [6:0] pat_tbl [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100};

  // Reference model state, held per digit position.
  int         m_code [N];
  bit         m_err  [N];
  bit         m_seen [N];
  int         m_cnt;
  int         m_last_d;
  logic [6:0] m_last_p;
  bit         m_done;
  bit         m_valid;

  function automatic void decode(input logic [6:0] p, output int code, output bit err);
    code = 14;
    err  = 1'b1;
    if (p == 7'b1111111) begin
      code = 15;
      err  = 1'b0;
    end
    for (int k = 0; k < 10; k++) begin
      if (pat_tbl[k] == p) begin
        code = k;
        err  = 1'b0;
      end
    end
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] d);
    int cnt = 0;
    int idx = -1;
    for (int i = 0; i < N; i++) begin
      if (d[i]) begin
        cnt++;
        idx = i;
      end
    end
    return (cnt == 1) ? idx : -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_code[i] = 15;
      m_err[i]  = 1'b0;
      m_seen[i] = 1'b0;
    end
    m_cnt    = 0;
    m_last_d = 0;
    m_last_p = 7'd0;
    m_done   = 1'b0;
    m_valid  = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit se, input logic [N-1:0] de, input logic [6:0] seg,
                            input bit rdy);
    bit     full;
    int     cd;
    int     d;
    int     c;
    bit     e;
    frame_t f;
    full = 1'b1;
    cd   = -1;
    for (int i = 0; i < N; i++) if (!m_seen[i]) full = 1'b0;
    if (se) begin
      d = onehot_idx(de);
      if (d < 0) begin
        m_cnt  = 0;
        m_done = 1'b0;
      end else begin
        if (d == m_last_d && seg == m_last_p) begin
          if (m_cnt < S) m_cnt++;
        end else begin
          m_last_d = d;
          m_last_p = seg;
          m_cnt    = 1;
          m_done   = 1'b0;
        end
        if (m_cnt == S && !m_done) begin
          cd     = d;
          m_done = 1'b1;
        end
      end
    end
    if (full && (!m_valid || rdy)) begin
      for (int i = 0; i < N; i++) begin
        f.bcd[4*i +: 4] = 4'(m_code[i]);
        f.err[i]        = m_err[i];
        m_seen[i]       = 1'b0;
      end
      exp_q.push_back(f);
      m_valid = 1'b1;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    if (cd >= 0) begin
      decode(seg, c, e);
      m_code[cd] = c;
      m_err[cd]  = e;
      m_seen[cd] = 1'b1;
    end
  endtask

  task automatic cycle(input bit se, input logic [N-1:0] de, input logic [6:0] seg,
                       input bit rdy);
    sample_en = se;
    dig_en    = de;
    seg_in    = seg;
    out_ready = rdy;
    @(posedge clk);
    model_step(se, de, seg, rdy);
    #1;
  endtask

  task automatic show(input int d, input logic [6:0] p, input int n, input bit rdy);
    repeat (n) cycle(1'b1, N'(1 << d), p, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) cycle(1'b0, '0, 7'h7F, rdy);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: a new frame is on the bus when valid is high and the previous
  // cycle either had no frame or completed a handshake.
  initial begin
    bit     pv;
    bit     pr;
    frame_t held;
    pv   = 1'b0;
    pr   = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
        pr = 1'b0;
      end else begin
        checks++;
        if (out_valid !== m_valid) begin
          errors++;
          $display("FAIL valid_timing actual=%0b expected=%0b t=%0t", out_valid, m_valid, $time);
        end
        if (out_valid && (!pv || pr)) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame actual=%h/%b expected=none t=%0t", out_bcd, out_err, $time);
          end else begin
            held = exp_q.pop_front();
            if ({out_bcd, out_err} !== held) begin
              errors++;
              $display("FAIL frame actual=%h/%b expected=%h/%b t=%0t", out_bcd, out_err,
                       held.bcd, held.err, $time);
            end
          end
        end else if (out_valid && pv && !pr) begin
          checks++;
          if ({out_bcd, out_err} !== held) begin
            errors++;
            $display("FAIL stall_hold actual=%h/%b expected=%h/%b t=%0t", out_bcd, out_err,
                     held.bcd, held.err, $time);
          end
        end
        pv = out_valid;
        pr = out_ready;
      end
    end
  end

  initial begin
    int         d;
    int         r;
    int         len;
    logic [6:0] p;
    bit         rdy;

    rst       = 1'b1;
    sample_en = 1'b0;
    dig_en    = '0;
    seg_in    = 7'h7F;
    out_ready = 1'b0;
    model_reset();
    #12;
    check("reset_bcd", 32'(out_bcd), 32'hFFFF);
    check("reset_err", 32'(out_err), 32'h0);
    check("reset_valid", 32'(out_valid), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic frame 4321, valid one cycle after the completing commit.
    show(0, pat_tbl[1], 3, 1'b1);
    show(1, pat_tbl[2], 3, 1'b1);
    show(2, pat_tbl[3], 3, 1'b1);
    show(3, pat_tbl[4], 3, 1'b1);
    check("first_valid_not_yet", 32'(out_valid), 32'h0);
    idle(1, 1'b1);
    check("first_valid", 32'(out_valid), 32'h1);
    check("first_bcd", 32'(out_bcd), 32'h4321);
    check("first_err", 32'(out_err), 32'h0);
    idle(2, 1'b1);

    // Short run on digit 1 must not commit.
    show(0, pat_tbl[3], 3, 1'b1);
    show(1, pat_tbl[1], 2, 1'b1);
    show(1, pat_tbl[2], 3, 1'b1);
    show(2, pat_tbl[0], 3, 1'b1);
    show(3, pat_tbl[9], 3, 1'b1);
    idle(1, 1'b1);
    check("short_run_bcd", 32'(out_bcd), 32'h9023);
    idle(2, 1'b1);

    // Invalid pattern on digit 2, then a blank on digit 0.
    show(0, pat_tbl[0], 3, 1'b1);
    show(1, pat_tbl[0], 3, 1'b1);
    show(2, 7'b1111110, 3, 1'b1);
    show(3, pat_tbl[0], 3, 1'b1);
    idle(1, 1'b1);
    check("invalid_bcd", 32'(out_bcd), 32'h0E00);
    check("invalid_err", 32'(out_err), 32'h4);
    show(0, 7'b1111111, 3, 1'b1);
    show(1, pat_tbl[0], 3, 1'b1);
    show(2, 7'b1111110, 3, 1'b1);
    show(3, pat_tbl[0], 3, 1'b1);
    idle(1, 1'b1);
    check("blank_bcd", 32'(out_bcd), 32'h0E0F);
    check("blank_err", 32'(out_err), 32'h4);
    idle(2, 1'b1);

    // Backpressure: 4321 stalls, 8888 waits in the shadow.
    for (int i = 0; i < N; i++) show(i, pat_tbl[i + 1], 3, 1'b0);
    for (int i = 0; i < N; i++) show(i, pat_tbl[8], 3, 1'b0);
    check("stall_bcd", 32'(out_bcd), 32'h4321);
    check("stall_valid", 32'(out_valid), 32'h1);
    idle(1, 1'b1);
    check("b2b_bcd", 32'(out_bcd), 32'h8888);
    check("b2b_valid", 32'(out_valid), 32'h1);
    idle(3, 1'b0);
    check("b2b_hold", 32'(out_bcd), 32'h8888);
    idle(2, 1'b1);

    // Disqualified samples restart the run; sample_en gaps do not.
    show(1, pat_tbl[1], 3, 1'b1);
    show(2, pat_tbl[2], 3, 1'b1);
    show(3, pat_tbl[3], 3, 1'b1);
    show(0, pat_tbl[5], 2, 1'b1);
    cycle(1'b1, 4'b0011, pat_tbl[5], 1'b1);
    show(0, pat_tbl[5], 2, 1'b1);
    cycle(1'b1, 4'b0000, pat_tbl[5], 1'b1);
    show(0, pat_tbl[5], 2, 1'b1);
    idle(1, 1'b1);
    check("restart_no_commit", 32'(out_valid), 32'h0);
    show(0, pat_tbl[7], 1, 1'b1);
    idle(2, 1'b1);
    show(0, pat_tbl[7], 1, 1'b1);
    idle(1, 1'b1);
    show(0, pat_tbl[7], 1, 1'b1);
    idle(1, 1'b1);
    check("gap_commit_bcd", 32'(out_bcd), 32'h3217);
    idle(2, 1'b1);

    // Asynchronous reset with a frame pending and a partial shadow.
    for (int i = 0; i < N; i++) show(i, pat_tbl[6 - i], 3, 1'b0);
    for (int i = 0; i < 3; i++) show(i, pat_tbl[9], 3, 1'b0);
    check("pre_reset_valid", 32'(out_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_bcd", 32'(out_bcd), 32'hFFFF);
    check("async_rst_err", 32'(out_err), 32'h0);
    check("async_rst_valid", 32'(out_valid), 32'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) show(i, pat_tbl[1], 3, 1'b1);
    idle(2, 1'b1);
    check("post_rst_partial", 32'(out_valid), 32'h0);
    show(3, pat_tbl[1], 3, 1'b1);
    idle(1, 1'b1);
    check("post_rst_bcd", 32'(out_bcd), 32'h1111);
    idle(2, 1'b1);

    // Randomized runs with gaps, bad enables and random backpressure.
    for (int n = 0; n < 300; n++) begin
      d = $urandom_range(0, N - 1);
      r = $urandom_range(0, 11);
      if (r < 10)
        p = pat_tbl[r];
      else if (r == 10)
        p = 7'b1111111;
      else
        p = 7'($urandom);
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) begin
        rdy = ($urandom_range(0, 3) != 0);
        r   = $urandom_range(0, 15);
        if (r == 0)
          cycle(1'b0, N'($urandom), 7'($urandom), rdy);
        else if (r == 1)
          cycle(1'b1, (($urandom_range(0, 1) == 0) ? 4'b0000 : 4'b0101), p, rdy);
        cycle(1'b1, N'(1 << d), p, rdy);
      end
    end

    idle(6, 1'b1);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
Name: seg7_capture

Overview:
- Receive-side counterpart of the BCD-to-7-segment path: samples a multiplexed 7-segment bus (segment lines plus one-hot digit enables) and reconstructs the BCD digit shown on each position.
- Each pattern must be held stable for a programmable number of samples before it is accepted.
- Once every position has been captured, the block publishes a full frame over a valid/ready handshake.
- Sits between the display-bus pins (or a loopback of the display driver) and the processor's readback/self-test logic.

Parameters:
- N_DIGITS, 4, number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 3, consecutive identical qualified samples required to accept a pattern (1..255).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sample_en  input  1  qualifies seg_in/dig_en for the current cycle.
- seg_in  input  7  segments {a,b,c,d,e,f,g}, active-low (0 = lit).
- dig_en  input  N_DIGITS  one-hot active-high position select; bit i = digit i.
- out_bcd  output  4*N_DIGITS  published frame; nibble i = digit i.
- out_err  output  N_DIGITS  per-digit flag: captured pattern not in table.
- out_valid  output  1  frame available.
- out_ready  input  1  consumer accepts the frame.

Behaviour:
- Decode table, seg_in {a..g} to code:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9.
  - 1111111 = blank, code 4'hF, err 0.
  - Any other pattern: code 4'hE, err 1.
- Reset (async, immediate): out_bcd all 4'hF, out_err 0, out_valid 0. Internal state is also cleared: shadow digits 4'hF, shadow err 0, seen mask 0, run counter 0, last digit/pattern 0, committed flag 0.
- Qualified sample: sample_en=1 and dig_en exactly one-hot.
  - sample_en=1 with dig_en zero or multi-hot: run counter to 0, committed flag cleared, no commit.
  - sample_en=0: all state held.
- Run tracking, per qualified sample:
  - Same digit and same pattern as the last sample: counter increments, saturating at STABLE_CYCLES.
  - Otherwise: last digit/pattern are replaced, counter = 1, committed flag cleared.
- Commit:
  - Occurs on the edge where the counter becomes STABLE_CYCLES and the committed flag is 0.
  - On that edge, the shadow nibble and shadow err for that digit are written, the seen bit is set, and the committed flag is set (exactly one commit per stable run).
  - STABLE_CYCLES=1: every run commits on its first sample.
- Publish:
  - Condition: seen mask all ones and (out_valid=0 or out_ready=1).
  - Action: out_bcd/out_err are loaded from the shadow, out_valid is set, and the seen mask is cleared.
  - Latency: out_valid is high 1 cycle after the commit that completes the mask.
  - A commit and a publish in the same cycle: publish uses the pre-commit shadow only if the mask was already full; otherwise it waits one cycle. The new commit's seen bit survives the clear.
- Handshake:
  - out_bcd/out_err are stable while out_valid=1 and out_ready=0.
  - out_valid=1 and out_ready=1 with no full mask: out_valid drops next cycle.
  - With a full mask, the next frame loads back-to-back in that cycle.
- Backpressure: commits continue into the shadow while the output is stalled. The newest value per digit wins; no overflow, no drop flag.
- Reset mid-run or mid-handshake: everything returns to reset values immediately, and the partial frame is discarded.

Decomposition:
- Shared package (seg7_pkg):
  - the ten digit segment constants and SEG_BLANK=7'b1111111;
  - CODE_BLANK=4'hF, CODE_ERR=4'hE;
  - function or localparam for the counter width, $clog2(STABLE_CYCLES+1).
- One combinational sub-module, seg7_to_bcd (7-bit pattern in, 4-bit code plus err out), instantiated once on seg_in.
- Run tracker, shadow registers and publish/handshake logic live in seg7_capture.

Test Plan:
- Reset, then digits 0..3 show patterns for 1,2,3,4, each held for 3 qualified samples, out_ready=1 -> out_valid rises 1 cycle after digit 3's 3rd sample; out_bcd=16'h4321, out_err=0.
- Digit 1 holds 1001111 for only 2 samples, then switches to 0010010 for 3 -> digit 1 commits 2; the frame shows nibble 1 = 2, never 1.
- Digit 2 shows pattern 1111110 (invalid) for 3 samples; others valid 0 -> out_bcd=16'h0E00, out_err=4'b0100. Digit 0 shows 1111111 -> nibble 4'hF, err 0.
- out_ready=0 while a full frame 16'h4321 is published, then digits repaint as 8,8,8,8 -> out_bcd holds 16'h4321. Raise out_ready -> next cycle out_bcd=16'h8888, out_valid stays 1; lower out_ready after that handshake -> out_bcd holds 16'h8888.
- dig_en=4'b0011 or 4'b0000 with sample_en=1 interleaved in a stable run of digit 0 -> counter restarts; a commit needs 3 fresh consecutive qualified samples. Samples with sample_en=0 inserted mid-run do not break the run.
- Assert rst asynchronously mid-frame with 3 of 4 digits seen and out_valid=1 -> outputs go to 4'hF/0/0 without a clock. After release, all 4 digits must be recaptured before out_valid rises.
